// File: rtl/wb_dma_arbiter.sv
// rtl/wb_dma_arbiter.sv - two-master round-robin Wishbone B3 arbiter in front of the memory slave
// Optional stall watchdog with FLUSH state: define WB_DMA_ARBITER_TIMEOUT_EN.
module wb_dma_arbiter #(
   parameter int WB_AW   = 32,
   parameter int WB_DW   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WB_AW-1:0]   m0_adr_i,
   input  logic [WB_DW-1:0]   m0_dat_i,
   input  logic [WB_DW/8-1:0] m0_sel_i,
   input  logic               m0_we_i,
   input  logic               m0_cyc_i,
   input  logic               m0_stb_i,
   input  logic [2:0]         m0_cti_i,
   input  logic [1:0]         m0_bte_i,
   output logic [WB_DW-1:0]   m0_dat_o,
   output logic               m0_ack_o,
   output logic               m0_err_o,
   input  logic [WB_AW-1:0]   m1_adr_i,
   input  logic [WB_DW-1:0]   m1_dat_i,
   input  logic [WB_DW/8-1:0] m1_sel_i,
   input  logic               m1_we_i,
   input  logic               m1_cyc_i,
   input  logic               m1_stb_i,
   input  logic [2:0]         m1_cti_i,
   input  logic [1:0]         m1_bte_i,
   output logic [WB_DW-1:0]   m1_dat_o,
   output logic               m1_ack_o,
   output logic               m1_err_o,
   output logic [WB_AW-1:0]   s_adr_o,
   output logic [WB_DW-1:0]   s_dat_o,
   output logic [WB_DW/8-1:0] s_sel_o,
   output logic               s_we_o,
   output logic               s_cyc_o,
   output logic               s_stb_o,
   output logic [2:0]         s_cti_o,
   output logic [1:0]         s_bte_o,
   input  logic [WB_DW-1:0]   s_dat_i,
   input  logic               s_ack_i,
   input  logic               s_err_i,
   output logic [1:0]         grant_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G0    = 2'd1,
      G1    = 2'd2
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
      , FLUSH = 2'd3
`endif
   } state_t;

   state_t state;
   logic   last;

`ifdef WB_DMA_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          stalled;
   logic          to_hit;

   // The error fires during the TIMEOUT-th consecutive stalled cycle.
   assign stalled = ((state == G0 && m0_stb_i) || (state == G1 && m1_stb_i))
                    && !s_ack_i && !s_err_i;
   assign to_hit  = stalled && (cnt == CW'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= 1'b1;
         grant_o <= 2'b00;
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
         cnt     <= '0;
`endif
      end else begin
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
         cnt <= (stalled && !to_hit) ? cnt + 1'b1 : '0;
`endif
         case (state)
            IDLE: begin
               // On a tie, the master that did not own the bus last wins.
               if (m0_cyc_i && (!m1_cyc_i || last)) begin
                  state   <= G0;
                  grant_o <= 2'b01;
               end else if (m1_cyc_i) begin
                  state   <= G1;
                  grant_o <= 2'b10;
               end
            end
            G0: begin
               if (!m0_cyc_i) begin
                  state   <= IDLE;
                  last    <= 1'b0;
                  grant_o <= 2'b00;
               end
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
               else if (to_hit) begin
                  state   <= FLUSH;
                  last    <= 1'b0;
                  grant_o <= 2'b00;
               end
`endif
            end
            G1: begin
               if (!m1_cyc_i) begin
                  state   <= IDLE;
                  last    <= 1'b1;
                  grant_o <= 2'b00;
               end
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
               else if (to_hit) begin
                  state   <= FLUSH;
                  last    <= 1'b1;
                  grant_o <= 2'b00;
               end
`endif
            end
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
            FLUSH: begin
               if (!(last ? m1_cyc_i : m0_cyc_i))
                  state <= IDLE;
            end
`endif
            default: begin
               state   <= IDLE;
               grant_o <= 2'b00;
            end
         endcase
      end
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_cti_o  = '0;
      s_bte_o  = '0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      if (state == G0) begin
         s_adr_o  = m0_adr_i;
         s_dat_o  = m0_dat_i;
         s_sel_o  = m0_sel_i;
         s_we_o   = m0_we_i;
         s_cyc_o  = m0_cyc_i;
         s_stb_o  = m0_stb_i;
         s_cti_o  = m0_cti_i;
         s_bte_o  = m0_bte_i;
         m0_dat_o = s_dat_i;
         m0_ack_o = s_ack_i;
         m0_err_o = s_err_i;
      end else if (state == G1) begin
         s_adr_o  = m1_adr_i;
         s_dat_o  = m1_dat_i;
         s_sel_o  = m1_sel_i;
         s_we_o   = m1_we_i;
         s_cyc_o  = m1_cyc_i;
         s_stb_o  = m1_stb_i;
         s_cti_o  = m1_cti_i;
         s_bte_o  = m1_bte_i;
         m1_dat_o = s_dat_i;
         m1_ack_o = s_ack_i;
         m1_err_o = s_err_i;
      end
`ifdef WB_DMA_ARBITER_TIMEOUT_EN
      if (to_hit) begin
         s_cyc_o = 1'b0;
         s_stb_o = 1'b0;
         if (state == G1)
            m1_err_o = 1'b1;
         else
            m0_err_o = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// tb/tb_wb_dma_arbiter.sv - directed self-checking bench for wb_dma_arbiter
module tb_wb_dma_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
   logic [2:0]  m0_cti_i, m1_cti_i;
   logic [1:0]  m0_bte_i, m1_bte_i;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i, s_err_i;
   logic [1:0]  grant_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_dma_arbiter #(.WB_AW(32), .WB_DW(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      s_ack_i = 0; s_err_i = 0;
      edge1();
      edge1();
      rst_n = 1'b1;
   endtask

   initial begin
      m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 4'hf; m0_we_i = 0; m0_cti_i = 0; m0_bte_i = 0;
      m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 4'hf; m1_we_i = 0; m1_cti_i = 0; m1_bte_i = 0;
      s_dat_i = 0;
      rst_n = 1'b0;
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      s_ack_i = 0; s_err_i = 0;
      #3;
      chk("rst_s_cyc", s_cyc_o, 0);
      chk("rst_grant", grant_o, 0);
      chk("rst_m0_ack", m0_ack_o, 0);
      do_reset();

      // single read from m0
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h1000;
      @(negedge clk);
      chk("t1_latency_cyc", s_cyc_o, 0);
      edge1();
      s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_s_cyc", s_cyc_o, 1);
      chk("t1_s_adr", s_adr_o, 32'h1000);
      chk("t1_grant", grant_o, 2'b01);
      chk("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
      chk("t1_m0_ack", m0_ack_o, 1);
      chk("t1_m1_ack", m1_ack_o, 0);
      chk("t1_m1_dat", m1_dat_o, 0);
      edge1();
      m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
      do_reset();

      // tie from reset, four alternating rounds
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      @(posedge clk);
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         chk($sformatf("t2_grant_r%0d", r), grant_o, (r % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("t2_cyc_r%0d", r), s_cyc_o, 1);
         edge1();
         if (r % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
         else begin m1_cyc_i = 0; m1_stb_i = 0; end
         edge1();
         if (r % 2 == 0) begin m0_cyc_i = 1; m0_stb_i = 1; end
         else begin m1_cyc_i = 1; m1_stb_i = 1; end
         @(negedge clk);
         chk($sformatf("t2_idle_grant_r%0d", r), grant_o, 0);
         chk($sformatf("t2_idle_cyc_r%0d", r), s_cyc_o, 0);
         @(posedge clk);
      end
      #1;
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      do_reset();

      // m1 8-beat incrementing write burst, m0 requests from beat 2
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_cti_i = 3'b010;
      m1_adr_i = 32'h2000; m1_dat_i = 0; s_ack_i = 1;
      @(posedge clk);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         chk($sformatf("t3_cyc_b%0d", b), s_cyc_o, 1);
         chk($sformatf("t3_grant_b%0d", b), grant_o, 2'b10);
         chk($sformatf("t3_adr_b%0d", b), s_adr_o, 32'h2000 + 4 * b);
         chk($sformatf("t3_dat_b%0d", b), s_dat_o, b);
         chk($sformatf("t3_cti_b%0d", b), s_cti_o, (b == 7) ? 3'b111 : 3'b010);
         chk($sformatf("t3_m0ack_b%0d", b), m0_ack_o, 0);
         edge1();
         if (b == 0) begin m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000; end
         if (b < 7) begin
            m1_adr_i = 32'h2000 + 4 * (b + 1);
            m1_dat_i = b + 1;
            m1_cti_i = (b + 1 == 7) ? 3'b111 : 3'b010;
         end else begin
            m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
         end
      end
      @(negedge clk);
      chk("t3_drop_cyc", s_cyc_o, 0);
      edge1();
      @(negedge clk);
      chk("t3_idle_grant", grant_o, 0);
      edge1();
      @(negedge clk);
      chk("t3_m0_grant", grant_o, 2'b01);

      // error on m0's second beat, then simultaneous ack+err
      edge1();
      s_ack_i = 1; s_dat_i = 32'h11111111;
      @(negedge clk);
      chk("t4_beat1_ack", m0_ack_o, 1);
      chk("t4_beat1_dat", m0_dat_o, 32'h11111111);
      edge1();
      s_ack_i = 0; s_err_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      @(negedge clk);
      chk("t4_m0_err", m0_err_o, 1);
      chk("t4_m1_err", m1_err_o, 0);
      chk("t4_m0_ack", m0_ack_o, 0);
      chk("t4_grant", grant_o, 2'b01);
      edge1();
      s_ack_i = 1; s_err_i = 1;
      @(negedge clk);
      chk("t4_both_ack", m0_ack_o, 1);
      chk("t4_both_err", m0_err_o, 1);
      chk("t4_held_grant", grant_o, 2'b01);
      edge1();
      s_ack_i = 0; s_err_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      edge1();
      edge1();
      @(negedge clk);
      chk("t4_m1_grant", grant_o, 2'b10);

      // asynchronous reset in the middle of m1's cycle
      chk("t5_pre_cyc", s_cyc_o, 1);
      #2;
      rst_n = 0;
      #1;
      chk("t5_rst_cyc", s_cyc_o, 0);
      chk("t5_rst_stb", s_stb_o, 0);
      chk("t5_rst_grant", grant_o, 0);
      m0_cyc_i = 1; m0_stb_i = 1;
      edge1();
      rst_n = 1;
      edge1();
      @(negedge clk);
      chk("t5_tie_grant", grant_o, 2'b01);
      m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;

`ifdef WB_DMA_ARBITER_TIMEOUT_EN
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1;
      @(posedge clk);
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         chk($sformatf("t6_noerr_%0d", k), m0_err_o, 0);
         chk($sformatf("t6_cyc_%0d", k), s_cyc_o, 1);
         if (k == 4) begin m1_cyc_i = 1; m1_stb_i = 1; end
         @(posedge clk);
      end
      @(negedge clk);
      chk("t6_err_pulse", m0_err_o, 1);
      chk("t6_cyc_forced", s_cyc_o, 0);
      chk("t6_stb_forced", s_stb_o, 0);
      chk("t6_m1_err", m1_err_o, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t6_err_once", m0_err_o, 0);
      chk("t6_flush_cyc", s_cyc_o, 0);
      edge1();
      m0_cyc_i = 0; m0_stb_i = 0;
      edge1();
      @(negedge clk);
      chk("t6_idle_grant", grant_o, 0);
      edge1();
      @(negedge clk);
      chk("t6_m1_grant", grant_o, 2'b10);
      m1_cyc_i = 0; m1_stb_i = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_dma_arbiter.md
Name: wb_dma_arbiter

Overview:
- Two-master, one-slave Wishbone B3 arbiter that shares the memory port between the stream DMA engine (m0) and a second bus master (m1, e.g. the CPU or a second DMA).
- Sits between the stream reader's wbm_* port and the SDRAM/memory controller slave.
- Grants ownership of the slave port for a whole bus cycle (cyc held), using round-robin priority.
- Muxes the request signals onto the slave port and routes the responses back to the granted master only.

Parameters:
- WB_AW, 32, address width.
- WB_DW, 32, data width; sel width is WB_DW/8.
- TIMEOUT, 1024, watchdog limit in cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_adr_i  in  WB_AW  master 0 address. Also, each 1 bit unless noted: m0_dat_i (WB_DW), m0_sel_i (WB_DW/8), m0_we_i, m0_cyc_i, m0_stb_i, m0_cti_i (3), m0_bte_i (2).
- m0_dat_o  out  WB_DW  read data to master 0. Also m0_ack_o (1), m0_err_o (1).
- m1_*  same set as m0_*, for master 1.
- s_adr_o  out  WB_AW  slave address. Also s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o, same widths as the master inputs.
- s_dat_i  in  WB_DW  slave read data. Also s_ack_i (1), s_err_i (1).
- grant_o  out  2  one-hot current owner; 2'b00 when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last=1 (so m0 wins the first tie).
  - grant_o=0.
  - All s_* outputs 0; all m*_ack_o/err_o 0; m*_dat_o 0.
- States: IDLE, G0, G1.
- IDLE transitions, evaluated on the clock edge:
  - Only m0_cyc_i high -> G0.
  - Only m1_cyc_i high -> G1.
  - Both high -> grant the master != last.
  - Neither high -> stay in IDLE.
- Arbitration latency: exactly 1 cycle. A master raising cyc in IDLE sees its signals on the s_* port the next cycle.
- In Gn, the s_* outputs are combinationally driven from master n.
- s_cyc_o = mn_cyc_i and s_stb_o = mn_stb_i while in Gn. In IDLE both are 0; s_adr/dat/sel/we/cti/bte may hold any value.
- mn_dat_o = s_dat_i, mn_ack_o = s_ack_i and mn_err_o = s_err_i while in Gn. The non-granted master sees ack=0 and err=0.
- Exit: in Gn, when mn_cyc_i is low at the edge -> IDLE, last=n.
  - At least one IDLE cycle separates two grants, so s_cyc_o drops for >=1 cycle between owners.
- No preemption:
  - Incremental bursts (cti=010) and multi-beat classic cycles stay with the owner until cyc drops.
  - The pending master waits indefinitely.
- Cyc dropped and re-raised by the owner in the same cycle it is released: the master must re-arbitrate from IDLE; round-robin favours the other master if it is pending.
- Simultaneous s_ack_i and s_err_i: both are forwarded unchanged.
- Reset asserted mid-burst: the grant is dropped immediately (asynchronous) and s_cyc_o/s_stb_o go to 0 the same instant.
- grant_o mirrors the state: G0=01, G1=10, IDLE=00.

Optional Feature:
- Macro: WB_DMA_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter of $clog2(TIMEOUT+1) bits runs while in Gn with mn_stb_i=1 and s_ack_i=0 and s_err_i=0.
  - The counter clears on any ack/err and on leaving Gn.
  - When it reaches TIMEOUT, the arbiter asserts mn_err_o for exactly one cycle in place of the slave response.
  - In that same cycle s_cyc_o/s_stb_o are forced to 0, and the state moves to the FLUSH state.
  - FLUSH waits for mn_cyc_i=0, then goes to IDLE with last=n.
- When not defined: no counter and no FLUSH state; a stalled slave hangs the owner forever.

Test Plan:
- After reset, only m0 raises cyc/stb with a single read to 0x1000, and the slave acks 1 cycle later with 0xDEADBEEF -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_dat_o=0xDEADBEEF with m0_ack_o=1, m1_ack_o stays 0, grant_o=01.
- m0 and m1 raise cyc in the same cycle from reset -> m0 is granted first; after m0 drops cyc there is 1 IDLE cycle, then grant_o=10. Repeating this 4 times gives alternating grants 01,10,01,10.
- m1 runs an 8-beat incremental write burst (cti 010...111) while m0 requests from beat 2 -> m1 keeps all 8 beats with no s_cyc_o gap; m0 is granted 2 cycles after m1_cyc_i falls.
- Slave asserts s_err_i on m0's second beat -> m0_err_o=1 that cycle, m1_err_o=0, and the grant is held until m0 drops cyc.
- Assert rst_n=0 mid-way through m1's burst -> s_cyc_o=0 and grant_o=00 immediately. After release, m0 wins a tie.
- With WB_DMA_ARBITER_TIMEOUT_EN, TIMEOUT=16, and the slave never acking -> m0_err_o pulses 1 cycle on the 16th stalled cycle and s_cyc_o drops. m1, if pending, is granted 2 cycles after m0 drops cyc.
